// File: rtl/time_seg_display.sv
// Latches washer times, converts each to BCD, and scans a 4-digit 7-segment display.
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit in each pair.
module time_seg_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_led,
  input  logic [5:0] time_now,
  input  logic [5:0] time_all,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       conv_busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV_NOW,
    CONV_ALL,
    COMMIT
  } state_t;

  localparam logic [19:0] LAST = 20'(SCAN_DIV - 1);

  state_t      state;
  logic [5:0]  now_lat, all_lat;
  logic [13:0] sr, sr_n;
  logic [2:0]  step;
  logic [7:0]  now_bcd, all_bcd;
  logic [3:0]  d0, d1, d2, d3;
  logic        start;

  logic [19:0] cnt, cnt_n;
  logic [1:0]  idx, idx_n;
  logic        wrap, blank;
  logic [3:0]  dig;
  logic [6:0]  glyph;

  function automatic logic [13:0] dd_step(input logic [13:0] s);
    logic [13:0] t;
    t = s;
    if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  function automatic logic [6:0] font(input logic [3:0] v);
    logic [6:0] f;
    f = 7'h7F;
    case (v)
      4'd0: f = 7'h40;
      4'd1: f = 7'h79;
      4'd2: f = 7'h24;
      4'd3: f = 7'h30;
      4'd4: f = 7'h19;
      4'd5: f = 7'h12;
      4'd6: f = 7'h02;
      4'd7: f = 7'h78;
      4'd8: f = 7'h00;
      4'd9: f = 7'h10;
      default: f = 7'h7F;
    endcase
    return f;
  endfunction

  assign sr_n  = dd_step(sr);
  assign start = (state == IDLE) &&
                 ({time_now, time_all} != {now_lat, all_lat});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      now_lat   <= '0;
      all_lat   <= '0;
      sr        <= '0;
      step      <= '0;
      now_bcd   <= '0;
      all_bcd   <= '0;
      d0        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      conv_busy <= 1'b0;
    end else begin
      conv_busy <= start || (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            now_lat <= time_now;
            all_lat <= time_all;
            sr      <= {8'd0, time_now};
            step    <= '0;
            state   <= CONV_NOW;
          end
        end
        CONV_NOW: begin
          sr   <= sr_n;
          step <= step + 3'd1;
          if (step == 3'd5) begin
            now_bcd <= sr_n[13:6];
            sr      <= {8'd0, all_lat};
            step    <= '0;
            state   <= CONV_ALL;
          end
        end
        CONV_ALL: begin
          sr   <= sr_n;
          step <= step + 3'd1;
          if (step == 3'd5) begin
            all_bcd <= sr_n[13:6];
            step    <= '0;
            state   <= COMMIT;
          end
        end
        COMMIT: begin
          // all four digits swap together
          d0    <= now_bcd[3:0];
          d1    <= now_bcd[7:4];
          d2    <= all_bcd[3:0];
          d3    <= all_bcd[7:4];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wrap  = (cnt == LAST);
    cnt_n = wrap ? 20'd0 : cnt + 20'd1;
    idx_n = wrap ? idx + 2'd1 : idx;
    dig   = d0;
    case (idx_n)
      2'd1:    dig = d1;
      2'd2:    dig = d2;
      2'd3:    dig = d3;
      default: dig = d0;
    endcase
    glyph = font(dig);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_n[0] && dig == 4'd0) glyph = 7'h7F;
`endif
    // last count of each slot is dark to avoid ghosting
    blank = !power_led || (cnt_n == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      if (blank) begin
        seg <= 8'hFF;
        an  <= 4'hF;
      end else begin
        seg <= {(idx_n != 2'd2), glyph};
        an  <= ~(4'b0001 << idx_n);
      end
    end
  end

endmodule

// File: doc/time_seg_display.md
Name: time_seg_display

Overview:
Downstream consumer of the washer remaining-time counters. Latches time_now (current phase remaining) and time_all (total remaining), converts each 6-bit binary value to two BCD digits with a sequential shift-add-3 engine, and drives a 4-digit multiplexed common-anode 7-segment display. Display layout is time_all on the left pair and time_now on the right pair, with a separator dot between the pairs.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is lit; legal range 2..2^20.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
power_led  input  1  power indicator; 0 blanks the display
time_now  input  6  current-phase remaining time, binary 0..63
time_all  input  6  total remaining time, binary 0..63
seg  output  8  active-low segments: [7]=dp, [6:0]=g,f,e,d,c,b,a
an  output  4  active-low digit enables; an[3] is the leftmost digit
conv_busy  output  1  1 while the BCD conversion FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - seg=8'hFF, an=4'b1111, conv_busy=0.
  - Digit registers, source latches, scan counter and digit index all go to 0; FSM goes to IDLE.
  - Reset asserted mid-conversion aborts the conversion; no partial result is committed.
- Conversion FSM states: IDLE, CONV_NOW, CONV_ALL, COMMIT.
  - IDLE: if {time_now,time_all} differs from the source latches, latch both inputs and go to CONV_NOW.
    - First cycle after reset: the latches are 0, so nonzero inputs trigger a conversion.
  - CONV_NOW: 6 cycles of shift-add-3 on latched time_now into an 8-bit BCD scratch; then go to CONV_ALL.
  - CONV_ALL: same 6 cycles on latched time_all; then go to COMMIT.
  - COMMIT: 1 cycle; all 4 digit registers load together, so the display never shows a half-updated value. Then go to IDLE.
- Latency and busy:
  - Inputs sampled at edge k → digit registers hold the new digits after edge k+13.
  - conv_busy=1 from edge k through edge k+13.
- Input changes while busy are ignored. They are detected on the first IDLE cycle after COMMIT; the newest value wins.
- Digit mapping:
  - d3 = time_all tens, d2 = time_all ones.
  - d1 = time_now tens, d0 = time_now ones.
  - Tens range 0..6, ones range 0..9.
- Scan:
  - A 20-bit counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
  - an = ~(4'b0001 << index).
  - seg[6:0] = font(d[index]); seg[7]=0 only when index==2, otherwise 1.
- Font (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Power-off blanking:
  - power_led=0 → an=4'b1111 and seg=8'hFF on the next clk edge.
  - Scan counter and conversion keep running, so the display is correct immediately when power returns.
- Outputs are registered; an and seg change on the same edge. Before each index change, one blank cycle (an=1111) is inserted to prevent ghosting. That cycle is counted inside SCAN_DIV.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when a pair's tens digit is 0, that tens digit is blanked (seg[6:0]=7'h7F). The dp on index 2 still shows.
- Undefined: all four digits always show, including leading zeros.

Test Plan:
1. Reset release with time_now=11, time_all=29, power_led=1, SCAN_DIV=4 → conv_busy high 14 cycles; digits become 2,9,1,1; an cycles 1110,1101,1011,0111; seg on index0 = 8'hF9 (1, dp off); index2 = 8'h10 (9, dp on).
2. Boundary values: time_now=63, time_all=0 → d1=6 (0000010), d0=3 (0110000), d3=d2=0 (1000000).
   - With LEADING_ZERO_BLANK_EN: d3 seg[6:0]=7F; d2 still shows 0 with dp.
3. Change time_now 11→10 at cycle k, then 10→9 at k+5 during conversion → commit at k+13 shows 10; second conversion starts in IDLE at k+14 and shows 09 after k+28; no intermediate mixed digits.
4. Drop power_led for 20 cycles mid-scan → an=1111 and seg=FF from the next edge; on restore, scan resumes at the correct index with the current digits.
5. Assert reset during CONV_ALL → outputs blank immediately and conv_busy=0; after release with unchanged nonzero inputs, a fresh 14-cycle conversion completes with correct digits.
6. Count down time_all 29→0 at one step per 100 cycles → each displayed value matches the binary input; the 0 step then 29 reload shows 00 then 29.
